// File: rtl/ctrl_pipeline.sv
// RV32I decode controller with a DEPTH-stage alignment pipeline, stall/flush,
// self-generated redirect kill and a wrapping redirect counter.
module ctrl_pipeline #(
  parameter int DEPTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic             stall,
  input  logic             flush,
  input  logic             take_branch,
  output logic             PC_Mux,
  output logic             WrEn_RF,
  output logic             CSRW_Mux,
  output logic             WrEn_DM,
  output logic             SE2_Ctrl,
  output logic [1:0]       WD_Mux,
  output logic [1:0]       ALU_Mux,
  output logic [1:0]       Branch_Mux,
  output logic [1:0]       RByteEn_DM,
  output logic [1:0]       WByteEn_DM,
  output logic [1:0]       DM_Mux,
  output logic             out_valid,
  output logic             redirect,
  output logic [DEPTH-1:0] stage_valid,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam int L = DEPTH - 1;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_OPI   = 7'b0010011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  logic [DEPTH-1:0] vld_p;
  logic [6:0]       op_p [DEPTH];
  logic [2:0]       f3_p [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic             pc_mux;

  // Stage 0 .. L: shift register; a committed redirect kills every stage and the input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        op_p[k] <= '0;
        f3_p[k] <= '0;
      end
      cnt_q <= '0;
    end else if (flush) begin
      vld_p <= '0;
    end else if (!stall) begin
      op_p[0]  <= in_opcode;
      f3_p[0]  <= in_funct3;
      vld_p[0] <= in_valid & ~pc_mux;
      for (int k = 1; k < DEPTH; k++) begin
        op_p[k]  <= op_p[k-1];
        f3_p[k]  <= f3_p[k-1];
        vld_p[k] <= vld_p[k-1] & ~pc_mux;
      end
      if (pc_mux) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Last stage decode; take_branch is the only input reaching an output
  logic [6:0] op_l;
  logic [2:0] f3_l;
  logic       v_l;
  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_sys, is_mem6;

  always_comb begin
    op_l     = op_p[L];
    f3_l     = f3_p[L];
    v_l      = vld_p[L];
    is_lui   = (op_l == OP_LUI);
    is_auipc = (op_l == OP_AUIPC);
    is_jal   = (op_l == OP_JAL);
    is_jalr  = (op_l == OP_JALR);
    is_br    = (op_l == OP_BR);
    is_ld    = (op_l == OP_LD);
    is_st    = (op_l == OP_ST);
    is_opi   = (op_l == OP_OPI);
    is_sys   = (op_l == OP_SYS);
    is_mem6  = (op_l[5:0] == 6'b100011);

    pc_mux     = 1'b0;
    WrEn_RF    = 1'b0;
    CSRW_Mux   = 1'b0;
    WrEn_DM    = 1'b0;
    SE2_Ctrl   = 1'b0;
    WD_Mux     = 2'b00;
    ALU_Mux    = 2'b00;
    Branch_Mux = 2'b00;
    RByteEn_DM = 2'b00;
    WByteEn_DM = 2'b00;
    DM_Mux     = 2'b00;
    if (v_l) begin
      pc_mux        = is_jal | is_jalr | (is_br & take_branch);
      WrEn_RF       = ~is_br & ~is_st;
      CSRW_Mux      = is_sys & f3_l[2];
      WrEn_DM       = is_st;
      SE2_Ctrl      = is_br;
      WD_Mux        = {is_auipc, is_lui};
      ALU_Mux[0]    = (is_opi & (f3_l[1:0] == 2'b01)) | is_mem6;
      ALU_Mux[1]    = is_jalr | is_ld | is_opi | is_mem6;
      Branch_Mux[0] = is_auipc | is_lui | is_jal;
      Branch_Mux[1] = is_jalr | is_ld | is_jal;
      RByteEn_DM    = f3_l[1:0];
      WByteEn_DM    = f3_l[1:0];
      DM_Mux[0]     = is_ld & ((f3_l == 3'b010) | (f3_l[2:1] == 2'b10));
      DM_Mux[1]     = is_ld & ~f3_l[1];
    end
  end

  assign PC_Mux       = pc_mux;
  assign redirect     = pc_mux;
  assign out_valid    = v_l;
  assign stage_valid  = vld_p;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scoreboard bench for ctrl_pipeline: queue-based reference pipeline, directed
// scenarios from the test plan, then randomized traffic with a mid-stream reset.
module tb_ctrl_pipeline;
  localparam int DEPTH = 3;
  localparam int CNT_W = 4;

  localparam bit [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                       JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011,
                       ST = 7'b0100011, OPI = 7'b0010011, SYS = 7'b1110011;

  logic clk = 0, rst_n = 0;
  logic in_valid = 0, stall = 0, flush = 0, take_branch = 0;
  logic [6:0] in_opcode = 0;
  logic [2:0] in_funct3 = 0;
  logic PC_Mux, WrEn_RF, CSRW_Mux, WrEn_DM, SE2_Ctrl, out_valid, redirect;
  logic [1:0] WD_Mux, ALU_Mux, Branch_Mux, RByteEn_DM, WByteEn_DM, DM_Mux;
  logic [DEPTH-1:0] stage_valid;
  logic [CNT_W-1:0] redirect_cnt;

  ctrl_pipeline #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_funct3(in_funct3), .stall(stall), .flush(flush), .take_branch(take_branch),
    .PC_Mux(PC_Mux), .WrEn_RF(WrEn_RF), .CSRW_Mux(CSRW_Mux), .WrEn_DM(WrEn_DM),
    .SE2_Ctrl(SE2_Ctrl), .WD_Mux(WD_Mux), .ALU_Mux(ALU_Mux), .Branch_Mux(Branch_Mux),
    .RByteEn_DM(RByteEn_DM), .WByteEn_DM(WByteEn_DM), .DM_Mux(DM_Mux),
    .out_valid(out_valid), .redirect(redirect), .stage_valid(stage_valid),
    .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pc, wrf, csrw, wdm, se2;
    logic [1:0] wd, alu, bm, rb, wb, dm;
    logic ov, redir;
    logic [DEPTH-1:0] sv;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  typedef struct packed { bit v; bit [6:0] op; bit [2:0] f3; } ent_t;

  obs_t act;
  assign act = {PC_Mux, WrEn_RF, CSRW_Mux, WrEn_DM, SE2_Ctrl, WD_Mux, ALU_Mux, Branch_Mux,
                RByteEn_DM, WByteEn_DM, DM_Mux, out_valid, redirect, stage_valid, redirect_cnt};

  ent_t pipe[$];   // pipe[0] youngest, pipe[DEPTH-1] oldest
  int   mcnt;
  obs_t expq[$];
  int   total = 0, bad = 0;

  task automatic chk(string name, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, a, e, $time);
    end
  endtask

  function automatic void model_reset();
    ent_t z = '0;
    pipe.delete();
    repeat (DEPTH) pipe.push_back(z);
    mcnt = 0;
  endfunction

  function automatic obs_t model_out();
    obs_t o = '0;
    ent_t e = pipe[DEPTH-1];
    bit lui, auipc, jal, jalr, br, ld, st, opi, sys, m6;
    for (int k = 0; k < DEPTH; k++) o.sv[k] = pipe[k].v;
    o.cnt = CNT_W'(mcnt);
    if (!e.v) return o;
    lui = e.op == LUI; auipc = e.op == AUIPC; jal = e.op == JAL; jalr = e.op == JALR;
    br = e.op == BR; ld = e.op == LD; st = e.op == ST; opi = e.op == OPI; sys = e.op == SYS;
    m6 = (e.op[5:0] == 6'b100011);
    o.ov    = 1;
    o.pc    = jal || jalr || (br && take_branch);
    o.redir = o.pc;
    o.wrf   = !br && !st;
    o.wdm   = st;
    o.csrw  = sys && e.f3[2];
    o.se2   = br;
    o.rb    = e.f3[1:0];
    o.wb    = e.f3[1:0];
    o.wd    = {auipc, lui};
    o.alu   = {jalr || ld || opi || m6, (opi && e.f3[1:0] == 2'b01) || m6};
    o.dm    = {ld && !e.f3[1], ld && (e.f3 == 3'd2 || e.f3[2:1] == 2'b10)};
    o.bm    = {jalr || ld || jal, auipc || lui || jal};
    return o;
  endfunction

  function automatic void model_step();
    obs_t o = model_out();
    ent_t n;
    if (!rst_n) begin
      model_reset();
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) pipe[k].v = 0;
    end else if (!stall) begin
      void'(pipe.pop_back());
      n.v = in_valid && !o.redir; n.op = in_opcode; n.f3 = in_funct3;
      pipe.push_front(n);
      if (o.redir) begin
        for (int k = 1; k < DEPTH; k++) pipe[k].v = 0;
        mcnt = (mcnt + 1) % (1 << CNT_W);
      end
    end
  endfunction

  // One cycle: publish expectation, let the edge happen, advance the model.
  task automatic cycle();
    expq.push_back(model_out());
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(bit v, bit [6:0] op, bit [2:0] f3, bit st = 0, bit fl = 0, bit tb = 0);
    in_valid = v; in_opcode = op; in_funct3 = f3; stall = st; flush = fl; take_branch = tb;
  endtask

  task automatic bubbles(int n);
    drive(0, 0, 0);
    repeat (n) cycle();
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) chk("bundle", act, expq.pop_front());
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  bit [6:0] ops [9] = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, SYS};

  initial begin
    int c0;
    bit prev_st;
    model_reset();
    @(posedge clk); #1;

    repeat (5) begin
      drive($urandom_range(0, 1), 7'($urandom), 3'($urandom), 0, 0, $urandom_range(0, 1));
      #1;
      chk("rst_sv", stage_valid, 0);
      chk("rst_out", {PC_Mux, WrEn_RF, WrEn_DM, out_valid}, 0);
      chk("rst_cnt", redirect_cnt, 0);
      cycle();
    end
    rst_n = 1;

    drive(1, LD, 3'b100); cycle(); bubbles(DEPTH - 1);
    chk("ld_dm", DM_Mux, 2'b11); chk("ld_alu", ALU_Mux, 2'b10); chk("ld_wrf", WrEn_RF, 1);
    drive(1, ST, 3'b010); cycle(); bubbles(DEPTH - 1);
    chk("st_wdm", WrEn_DM, 1); chk("st_wrf", WrEn_RF, 0); chk("st_alu", ALU_Mux, 2'b11);

    for (int o = 0; o < 9; o++)
      for (int f = 0; f < 8; f++) begin
        drive(1, ops[o], 3'(f), 0, 0, $urandom_range(0, 1));
        cycle();
      end
    drive(0, 0, 0, 0, 1); cycle(); bubbles(1);

    c0 = mcnt;
    drive(1, BR, 0); cycle(); drive(1, OPI, 0); cycle(); cycle();
    drive(1, OPI, 0, 0, 0, 1); #1;
    chk("br_pc", PC_Mux, 1); chk("br_redir", redirect, 1);
    cycle(); drive(0, 0, 0); #1;
    chk("br_sv", stage_valid, 0); chk("br_cnt", redirect_cnt, (c0 + 1) % 16);
    bubbles(DEPTH);

    c0 = mcnt;
    drive(1, BR, 0); cycle(); drive(1, OPI, 0); cycle(); cycle();
    drive(1, OPI, 0, 0, 0, 0); #1;
    chk("nt_pc", PC_Mux, 0);
    cycle(); drive(0, 0, 0); #1;
    chk("nt_sv", stage_valid, 3'b111); chk("nt_cnt", redirect_cnt, c0);
    bubbles(DEPTH);

    drive(1, JAL, 0); cycle(); bubbles(DEPTH - 1);
    c0 = mcnt;
    repeat (3) begin
      drive(1, OPI, 0, 1); #1;
      chk("stall_pc", PC_Mux, 1); chk("stall_cnt", redirect_cnt, c0);
      cycle();
    end
    drive(0, 0, 0); #1; chk("stall_pc_rel", PC_Mux, 1);
    cycle();
    chk("stall_cnt_inc", redirect_cnt, (c0 + 1) % 16); chk("stall_sv", stage_valid, 0);

    drive(1, JAL, 0); cycle(); bubbles(DEPTH - 1);
    c0 = mcnt;
    drive(1, OPI, 0, 0, 1); #1; chk("fl_pc", PC_Mux, 1);
    cycle(); drive(0, 0, 0); #1;
    chk("fl_sv", stage_valid, 0); chk("fl_cnt", redirect_cnt, c0);
    chk("fl_out", {PC_Mux, WrEn_RF, out_valid}, 0);

    c0 = mcnt;
    repeat (17) begin
      drive(1, JAL, 0); cycle(); bubbles(DEPTH);
    end
    chk("wrap_cnt", redirect_cnt, (c0 + 1) % 16);

    prev_st = 0;
    for (int i = 0; i < 2000; i++) begin
      bit st = ($urandom_range(0, 99) < 15);
      bit tb = (st && prev_st) ? take_branch : 1'($urandom_range(0, 1));
      bit [6:0] op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      drive($urandom_range(0, 99) < 80, op, 3'($urandom), st, $urandom_range(0, 99) < 5, tb);
      prev_st = st;
      if (i == 700) begin
        rst_n = 0; #1;
        chk("arst_sv", stage_valid, 0); chk("arst_cnt", redirect_cnt, 0);
        chk("arst_out", {PC_Mux, WrEn_RF, WrEn_DM, out_valid, DM_Mux, ALU_Mux}, 0);
        model_reset();
        cycle(); cycle();
        rst_n = 1;
      end
      cycle();
    end
    bubbles(3);
    @(negedge clk); #1;
    chk("drain", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
